fast_frame_sequencer: RTL
=========================

// Module: fast_frame_sequencer
// PURPOSE
//  Frame-level controller for the FAST_with_NMS corner pipeline. On a start pulse it reads one
//  IMG_ROW x IMG_COL greyscale frame from a single-port frame buffer in raster order and drives
//  the pipeline's ce/data_in, with optional per-row blanking. It then drains the pipeline, forwards
//  each detected corner on a valid/ready port, counts corners and signals done.
//  Sits between the frame-buffer read port and the FAST_with_NMS instance.
// PARAMETERS
//  IMG_COL       640   pixels per row
//  IMG_ROW       480   rows per frame
//  PIXEL_WIDTH   8     pixel bit width
//  ADDR_WIDTH    19    frame-buffer address width (>= clog2(IMG_COL*IMG_ROW))
//  COORD_WIDTH   10    width of FAST x/y coordinates
//  CNT_WIDTH     16    corner / drop counter width (saturating)
//  HBLANK        0     idle cycles (fast_ce=0) inserted after each row; 0 = none
//  DRAIN_MAX     4096  max DRAIN cycles before timeout
// PORTS
//  clk            in   1            clock
//  rst_n          in   1            asynchronous, active-low reset
//  start          in   1            1-cycle request to process a frame (sampled only in IDLE)
//  abort          in   1            cancel the current frame, any state
//  busy           out  1            high in FETCH/HBLANK/DRAIN
//  done           out  1            1-cycle pulse at end of frame
//  timeout        out  1            sticky: DRAIN_MAX reached; cleared on start
//  mem_rd_en      out  1            frame-buffer read enable
//  mem_rd_addr    out  ADDR_WIDTH   read address = row*IMG_COL+col
//  mem_rd_data    in   PIXEL_WIDTH  read data, valid 1 cycle after mem_rd_en
//  fast_ce        out  1            pipeline clock enable
//  fast_data      out  PIXEL_WIDTH  pipeline pixel input
//  fast_iscorner  in   1            corner strobe from pipeline
//  fast_x         in   COORD_WIDTH  pipeline x coordinate
//  fast_y         in   COORD_WIDTH  pipeline y coordinate
//  corner_valid   out  1            corner output valid
//  corner_x       out  COORD_WIDTH  corner x
//  corner_y       out  COORD_WIDTH  corner y
//  corner_ready   in   1            downstream accept
//  corner_count   out  CNT_WIDTH    corners detected this frame; held after done until next start
//  drop_count     out  CNT_WIDTH    corners lost to backpressure this frame
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0: busy, done, timeout, mem_rd_en, mem_rd_addr, fast_ce,
//   corner_valid, corner_x/y, corner_count, drop_count. fast_data follows mem_rd_data.
//  States and transitions:
//   IDLE   -> FETCH on start. Row/col counters, corner_count, drop_count and timeout are cleared.
//   FETCH  asserts mem_rd_en=1 every cycle; address increments by 1 per cycle.
//           At col==IMG_COL-1, col wraps to 0 and row increments.
//           After the last pixel of a row: -> HBLANK if HBLANK>0 and it is not the last row.
//           After the last pixel of the frame -> DRAIN.
//   HBLANK mem_rd_en=0 for exactly HBLANK cycles, then -> FETCH.
//   DRAIN  fast_ce=1, fast_data=0 each cycle. Exit -> DONE on the first cycle with
//           fast_x==IMG_COL-1 and fast_y==IMG_ROW-1. Otherwise, after DRAIN_MAX cycles,
//           set timeout=1 and -> DONE.
//   DONE   done=1 for one cycle -> IDLE. A start in this cycle is ignored.
//  Read alignment: fast_ce is mem_rd_en registered once; fast_data=mem_rd_data (combinational)
//   whenever the registered enable is high. Pixel k reaches the pipeline exactly 1 cycle after its read.
//  Corner port:
//   - A fast_iscorner pulse, sampled in FETCH/HBLANK/DRAIN, loads corner_x/y and sets
//     corner_valid=1 the next cycle.
//   - corner_valid stays 1 until corner_valid&&corner_ready. corner_x/y are stable while stalled.
//   - New corner arriving while stalled (valid&&!ready): the new corner is dropped and drop_count
//     increments; the held corner is kept.
//   - Accept and new corner in the same cycle: the new corner is loaded, no drop.
//  Counting: corner_count increments on every sampled fast_iscorner, including dropped ones.
//   Both counters saturate at all-ones.
//  abort (any state, highest priority): next cycle state=IDLE; mem_rd_en, fast_ce, corner_valid,
//   busy forced 0; no done pulse. Counters are held.
//  start while busy is ignored. The sequencer never stalls the pipeline for backpressure.
// TESTING
//  1. IMG_COL=8, IMG_ROW=8, HBLANK=0, ramp frame -> 64 consecutive mem_rd_en cycles, addr 0..63;
//     fast_data==addr[7:0] one cycle later.
//  2. HBLANK=3, 8x8 frame -> fast_ce low for exactly 3 cycles after each of rows 0..6, never
//     after row 7; 64 ce-high cycles before DRAIN.
//  3. Full 640x480 frame with the single-corner test patch at (3,3) -> corner_valid once with
//     x=3, y=3; done pulse; corner_count==1; timeout==0.
//  4. corner_ready=0, three iscorner pulses -> first corner held, drop_count==2, corner_count==3;
//     raise ready -> one handshake.
//  5. abort mid-FETCH at row 2 -> next cycle busy=0, mem_rd_en=0, no done; a new start
//     restarts at addr 0 with counters cleared.
//  6. Pipeline model that never reaches the last coordinate, DRAIN_MAX=16 -> done after
//     16 DRAIN cycles with timeout=1.

Source files
------------

// File: rtl/fast_frame_sequencer.sv
// Frame-level controller for the FAST_with_NMS corner pipeline: streams one frame from the
// frame buffer into the pipeline, drains it, and forwards detected corners on a valid/ready port.
module fast_frame_sequencer #(
  parameter int IMG_COL     = 640,
  parameter int IMG_ROW     = 480,
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = 19,
  parameter int COORD_WIDTH = 10,
  parameter int CNT_WIDTH   = 16,
  parameter int HBLANK      = 0,
  parameter int DRAIN_MAX   = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
  input  logic [PIXEL_WIDTH-1:0] mem_rd_data,
  output logic                   fast_ce,
  output logic [PIXEL_WIDTH-1:0] fast_data,
  input  logic                   fast_iscorner,
  input  logic [COORD_WIDTH-1:0] fast_x,
  input  logic [COORD_WIDTH-1:0] fast_y,
  output logic                   corner_valid,
  output logic [COORD_WIDTH-1:0] corner_x,
  output logic [COORD_WIDTH-1:0] corner_y,
  input  logic                   corner_ready,
  output logic [CNT_WIDTH-1:0]   corner_count,
  output logic [CNT_WIDTH-1:0]   drop_count
);

  localparam int COL_W = (IMG_COL   > 1) ? $clog2(IMG_COL)   : 1;
  localparam int ROW_W = (IMG_ROW   > 1) ? $clog2(IMG_ROW)   : 1;
  localparam int BLK_W = (HBLANK    > 1) ? $clog2(HBLANK)    : 1;
  localparam int DRN_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HBLANK,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                 state_q;
  logic [COL_W-1:0]       col_q;
  logic [ROW_W-1:0]       row_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BLK_W-1:0]       blank_cnt_q;
  logic [DRN_W-1:0]       drain_cnt_q;
  logic                   rd_en_q;
  logic                   ce_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   timeout_q;
  logic                   corner_valid_q;
  logic [COORD_WIDTH-1:0] corner_x_q;
  logic [COORD_WIDTH-1:0] corner_y_q;
  logic [CNT_WIDTH-1:0]   corner_count_q;
  logic [CNT_WIDTH-1:0]   drop_count_q;

  logic last_col;
  logic last_row;
  logic last_coord;
  logic start_frame;
  logic in_frame;
  logic sample_corner;
  logic accept;
  logic load_corner;

  assign last_col      = (col_q == COL_W'(IMG_COL - 1));
  assign last_row      = (row_q == ROW_W'(IMG_ROW - 1));
  assign last_coord    = (fast_x == COORD_WIDTH'(IMG_COL - 1)) &&
                         (fast_y == COORD_WIDTH'(IMG_ROW - 1));
  assign start_frame   = (state_q == S_IDLE) && start;
  assign in_frame      = (state_q == S_FETCH) || (state_q == S_HBLANK) || (state_q == S_DRAIN);
  assign sample_corner = in_frame && fast_iscorner;
  assign accept        = corner_valid_q && corner_ready;
  // A new corner may only overwrite the holding register when it is empty or being accepted.
  assign load_corner   = sample_corner && (!corner_valid_q || corner_ready);

  // NOTE: every register below is updated with <= so all flops see pre-edge values;
  // a blocking = here would let later statements read already-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: only control/datapath registers need reset; there is no storage array here.
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      blank_cnt_q <= '0;
      drain_cnt_q <= '0;
      rd_en_q     <= 1'b0;
      ce_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else if (abort) begin
      state_q <= S_IDLE;
      rd_en_q <= 1'b0;
      ce_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ce_q   <= rd_en_q;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_FETCH;
            rd_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            addr_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            timeout_q <= 1'b0;
          end
        end
        S_FETCH: begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          if (last_col) begin
            col_q <= '0;
            if (last_row) begin
              state_q     <= S_DRAIN;
              rd_en_q     <= 1'b0;
              drain_cnt_q <= '0;
            end else begin
              row_q <= row_q + ROW_W'(1);
              if (HBLANK > 0) begin
                state_q     <= S_HBLANK;
                rd_en_q     <= 1'b0;
                blank_cnt_q <= '0;
              end
            end
          end else begin
            col_q <= col_q + COL_W'(1);
          end
        end
        S_HBLANK: begin
          if (blank_cnt_q == BLK_W'(HBLANK - 1)) begin
            state_q <= S_FETCH;
            rd_en_q <= 1'b1;
          end else begin
            blank_cnt_q <= blank_cnt_q + BLK_W'(1);
          end
        end
        S_DRAIN: begin
          if (last_coord) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (drain_cnt_q == DRN_W'(DRAIN_MAX - 1)) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRN_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Corner holding register and per-frame saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corner_valid_q <= 1'b0;
      corner_x_q     <= '0;
      corner_y_q     <= '0;
      corner_count_q <= '0;
      drop_count_q   <= '0;
    end else if (abort) begin
      corner_valid_q <= 1'b0;
    end else begin
      if (load_corner) begin
        corner_valid_q <= 1'b1;
        corner_x_q     <= fast_x;
        corner_y_q     <= fast_y;
      end else if (accept) begin
        corner_valid_q <= 1'b0;
      end

      if (start_frame) begin
        corner_count_q <= '0;
        drop_count_q   <= '0;
      end else if (sample_corner) begin
        if (corner_count_q != '1) corner_count_q <= corner_count_q + CNT_WIDTH'(1);
        if (!load_corner && drop_count_q != '1) drop_count_q <= drop_count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign mem_rd_en    = rd_en_q;
  assign mem_rd_addr  = addr_q;
  // The first DRAIN cycle still carries the last pixel, so only zero the data once ce_q drops.
  assign fast_ce      = ce_q || (state_q == S_DRAIN);
  assign fast_data    = ((state_q == S_DRAIN) && !ce_q) ? '0 : mem_rd_data;
  assign corner_valid = corner_valid_q;
  assign corner_x     = corner_x_q;
  assign corner_y     = corner_y_q;
  assign corner_count = corner_count_q;
  assign drop_count   = drop_count_q;

endmodule
